// File: rtl/mod_mul.sv
// Sequential 256-bit modular multiplier over the secp256k1 prime, MSB-first double-and-add.
// Optional MOD_MUL_ONE_FLAG_EN adds an is_one result flag registered with product.
module mod_mul #(
    parameter int unsigned             WIDTH = 256,
    parameter logic [WIDTH-1:0]        P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic [WIDTH-1:0] product,
    output logic             busy,
`ifdef MOD_MUL_ONE_FLAG_EN
    output logic             is_one,
`endif
    output logic             done
);

    localparam int unsigned      CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH:0]   P_EXT   = {1'b0, P};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
    } state_t;

    state_t             r_state,   w_nxt_state;
    logic [WIDTH-1:0]   r_acc,     w_nxt_acc;
    logic [WIDTH-1:0]   r_a,       w_nxt_a;
    logic [WIDTH-1:0]   r_b,       w_nxt_b;
    logic [CNT_W-1:0]   r_cnt,     w_nxt_cnt;
    logic [WIDTH-1:0]   r_product, w_nxt_product;
    logic               r_busy,    w_nxt_busy;
    logic               r_done,    w_nxt_done;
    logic               r_is_one,  w_nxt_is_one;

    logic [WIDTH:0]     w_dbl;
    logic [WIDTH-1:0]   w_d;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_sum_red;
    logic [WIDTH-1:0]   w_s;
    logic [WIDTH-1:0]   w_a_red;

    // One double-and-add step: two compare/subtract stages keep acc below P.
    assign w_dbl     = {r_acc, 1'b0};
    assign w_d       = WIDTH'((w_dbl >= P_EXT) ? (w_dbl - P_EXT) : w_dbl);
    assign w_sum     = {1'b0, w_d} + {1'b0, r_a};
    assign w_sum_red = WIDTH'((w_sum >= P_EXT) ? (w_sum - P_EXT) : w_sum);
    assign w_s       = r_b[r_cnt] ? w_sum_red : w_d;

    // 2^256 < 2P, so one conditional subtraction fully reduces the multiplicand.
    assign w_a_red   = (input_a >= P) ? (input_a - P) : input_a;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_is_one  <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_acc     <= w_nxt_acc;
            r_a       <= w_nxt_a;
            r_b       <= w_nxt_b;
            r_cnt     <= w_nxt_cnt;
            r_product <= w_nxt_product;
            r_busy    <= w_nxt_busy;
            r_done    <= w_nxt_done;
            r_is_one  <= w_nxt_is_one;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_acc     = r_acc;
        w_nxt_a       = r_a;
        w_nxt_b       = r_b;
        w_nxt_cnt     = r_cnt;
        w_nxt_product = r_product;
        w_nxt_busy    = r_busy;
        w_nxt_done    = 1'b0;
        w_nxt_is_one  = r_is_one;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_a     = w_a_red;
                    w_nxt_b     = input_b;
                    w_nxt_acc   = '0;
                    w_nxt_cnt   = CNT_MAX;
                    w_nxt_busy  = 1'b1;
                    w_nxt_state = S_RUN;
                end
            end
            S_RUN: begin
                w_nxt_acc = w_s;
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_nxt_product = w_s;
                    w_nxt_is_one  = (w_s == ONE);
                    w_nxt_done    = 1'b1;
                    w_nxt_busy    = 1'b0;
                    w_nxt_state   = S_IDLE;
                end
            end
            default: begin
                w_nxt_busy  = 1'b0;
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    assign product = r_product;
    assign busy    = r_busy;
    assign done    = r_done;

`ifdef MOD_MUL_ONE_FLAG_EN
    assign is_one  = r_is_one;
`else
    logic w_is_one_unused;
    assign w_is_one_unused = r_is_one;
`endif

endmodule

// File: tb/tb_mod_mul.sv
// Self-checking bench for mod_mul against an arbitrary-precision (a*b) mod P reference.
// Build with MOD_MUL_ONE_FLAG_EN defined to also check is_one.
module tb_mod_mul;

    localparam logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam int TIMEOUT = 400;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] input_a;
    logic [255:0] input_b;
    logic [255:0] product;
    logic         busy;
    logic         done;
    logic         one_flag;

    int checks   = 0;
    int failures = 0;

    mod_mul dut (
        .clk     (clk),
        .reset   (rst_n),
        .start   (start),
        .input_a (input_a),
        .input_b (input_b),
        .product (product),
        .busy    (busy),
`ifdef MOD_MUL_ONE_FLAG_EN
        .is_one  (one_flag),
`endif
        .done    (done)
    );

`ifndef MOD_MUL_ONE_FLAG_EN
    assign one_flag = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] ref_mul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = 512'(a) * 512'(b);
        return 256'(t % 512'(P));
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drive one operation and wait for done; returns result, latency and post-done status.
    task automatic do_op(input logic [255:0] a, input logic [255:0] b,
                         output logic [255:0] prod, output int lat, output logic one,
                         output logic busy_after, output logic done_after);
        @(negedge clk);
        input_a = a;
        input_b = b;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        input_a = rand256();
        input_b = rand256();
        lat = 0;
        while (lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        prod = product;
        one  = one_flag;
        @(posedge clk); #1;
        busy_after = busy;
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; input_a = '0; input_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (product !== 256'd0) begin failures++; $display("FAIL reset_product got=%h exp=0", product); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [255:0] prod; int lat; logic one, ba, da;
        do_op(256'd3, 256'd5, prod, lat, one, ba, da);
        checks++; if (lat !== 256) begin failures++; $display("FAIL basic_latency got=%0d exp=256", lat); end
        checks++; if (prod !== 256'd15) begin failures++; $display("FAIL basic_product got=%h exp=15", prod); end
        checks++; if (ba !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", ba); end
        checks++; if (da !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b exp=0", da); end
        // busy must rise on the accept edge
        @(negedge clk); input_a = 256'd7; input_b = 256'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_run got=%b exp=1", busy); end
        checks++; if (product !== 256'd15) begin failures++; $display("FAIL basic_product_hold got=%h exp=15", product); end
        repeat (260) @(posedge clk);
        #1;
        checks++; if (product !== 256'd63) begin failures++; $display("FAIL basic_second got=%h exp=63", product); end
    endtask

    task automatic test_wrap();
        logic [255:0] prod; int lat; logic one, ba, da;
        do_op(P - 256'd1, P - 256'd1, prod, lat, one, ba, da);
        checks++; if (prod !== 256'd1) begin failures++; $display("FAIL wrap_pm1_sq got=%h exp=1", prod); end
`ifdef MOD_MUL_ONE_FLAG_EN
        checks++; if (one !== 1'b1) begin failures++; $display("FAIL wrap_is_one got=%b exp=1", one); end
`endif
        do_op(P - 256'd1, 256'd2, prod, lat, one, ba, da);
        checks++; if (prod !== P - 256'd2) begin failures++; $display("FAIL wrap_pm1_x2 got=%h exp=%h", prod, P - 256'd2); end
`ifdef MOD_MUL_ONE_FLAG_EN
        checks++; if (one !== 1'b0) begin failures++; $display("FAIL wrap_not_one got=%b exp=0", one); end
`endif
    endtask

    task automatic test_reduce_zero();
        logic [255:0] prod; int lat; logic one, ba, da;
        do_op(P + 256'd2, 256'd3, prod, lat, one, ba, da);
        checks++; if (prod !== 256'd6) begin failures++; $display("FAIL reduce_a got=%h exp=6", prod); end
        do_op(P, 256'hDEADBEEF, prod, lat, one, ba, da);
        checks++; if (prod !== 256'd0) begin failures++; $display("FAIL zero_a_eq_p got=%h exp=0", prod); end
        do_op(256'h1234, 256'd0, prod, lat, one, ba, da);
        checks++; if (prod !== 256'd0) begin failures++; $display("FAIL zero_b got=%h exp=0", prod); end
        do_op(256'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
              256'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
              prod, lat, one, ba, da);
        checks++; if (prod !== ref_mul('1, '1)) begin failures++; $display("FAIL reduce_all_ones got=%h exp=%h", prod, ref_mul('1, '1)); end
    endtask

    task automatic test_inverse();
        logic [255:0] prod; int lat; logic one, ba, da;
        do_op(256'd2, (P + 256'd1) >> 1, prod, lat, one, ba, da);
        checks++; if (prod !== 256'd1) begin failures++; $display("FAIL inverse_2 got=%h exp=1", prod); end
`ifdef MOD_MUL_ONE_FLAG_EN
        checks++; if (one !== 1'b1) begin failures++; $display("FAIL inverse_is_one got=%b exp=1", one); end
`endif
    endtask

    task automatic test_random();
        logic [255:0] a, b, prod, exp_p; int lat; logic one, ba, da;
        for (int n = 0; n < 8; n++) begin
            a = rand256();
            b = rand256();
            if (n == 0) a = P + (a >> 224);
            exp_p = ref_mul(a, b);
            do_op(a, b, prod, lat, one, ba, da);
            checks++; if (prod !== exp_p) begin failures++; $display("FAIL random_%0d got=%h exp=%h", n, prod, exp_p); end
            checks++; if (lat !== 256) begin failures++; $display("FAIL random_lat_%0d got=%0d exp=256", n, lat); end
`ifdef MOD_MUL_ONE_FLAG_EN
            checks++; if (one !== (exp_p == 256'd1)) begin failures++; $display("FAIL random_one_%0d got=%b exp=%b", n, one, exp_p == 256'd1); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] a1, b1, a2, b2, p1; int n;
        a1 = rand256(); b1 = rand256(); a2 = rand256(); b2 = rand256();
        @(negedge clk); input_a = a1; input_b = b1; start = 1'b1;
        @(posedge clk); #1;
        input_a = a2; input_b = b2;
        n = 0;
        while (n < TIMEOUT) begin
            @(posedge clk); #1; n++;
            if (done) break;
        end
        p1 = product;
        checks++; if (n !== 256) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=256", n); end
        checks++; if (p1 !== ref_mul(a1, b1)) begin failures++; $display("FAIL b2b_first got=%h exp=%h", p1, ref_mul(a1, b1)); end
        n = 0;
        while (n < TIMEOUT) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept got=busy%b/done%b exp=busy1/done0", busy, done); end
                start = 1'b0;
                input_a = rand256();
            end
            if (done) break;
        end
        checks++; if (n !== 257) begin failures++; $display("FAIL b2b_spacing got=%0d exp=257", n); end
        checks++; if (product !== ref_mul(a2, b2)) begin failures++; $display("FAIL b2b_second got=%h exp=%h", product, ref_mul(a2, b2)); end
    endtask

    task automatic test_busy_ignore();
        logic [255:0] a, b; int n;
        a = rand256(); b = rand256();
        @(negedge clk); input_a = a; input_b = b; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk); input_a = rand256(); input_b = rand256(); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 51;
        while (n < TIMEOUT) begin
            @(posedge clk); #1; n++;
            if (done) break;
        end
        checks++; if (n !== 256) begin failures++; $display("FAIL ignore_lat got=%0d exp=256", n); end
        checks++; if (product !== ref_mul(a, b)) begin failures++; $display("FAIL ignore_product got=%h exp=%h", product, ref_mul(a, b)); end
    endtask

    task automatic test_reset_mid();
        logic [255:0] prod; int lat, dones; logic one, ba, da;
        do_op(256'd11, 256'd13, prod, lat, one, ba, da);
        @(negedge clk); input_a = rand256(); input_b = rand256(); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (100) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        checks++; if (product !== 256'd0) begin failures++; $display("FAIL midrst_product got=%h exp=0", product); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
        do_op(256'd123456789, 256'd987654321, prod, lat, one, ba, da);
        checks++; if (prod !== ref_mul(256'd123456789, 256'd987654321)) begin failures++; $display("FAIL midrst_recover got=%h exp=%h", prod, ref_mul(256'd123456789, 256'd987654321)); end
        checks++; if (lat !== 256) begin failures++; $display("FAIL midrst_recover_lat got=%0d exp=256", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_reduce_zero();
        test_inverse();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
